// File: rtl/countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer_ctrl
// Purpose  : Sequencer for the MM:SS BCD down-counter chain. It turns
//            debounced one-cycle button pulses into set/clear/decrement
//            strobes, generates the 1 s borrow into sec0 and raises the
//            alarm at the 00:00 terminal count.
// Ports    : clk, rst_n (async, active low)
//            pb_start/pb_set/pb_inc/pb_clr : one-cycle button pulses
//            cnt_zero                       : chain reads 00:00
//            de_en, br_s0                   : decrement enable / 1 s borrow
//            set_en, set_sel, set_val       : digit load strobe/select/value
//            rst_f                          : one-cycle clear of all digits
//            alarm, state                   : terminal flag / FSM state
// Options  : ALARM_BLINK_EN - alarm toggles every TICK_DIV clocks in DONE
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer_ctrl #(
    parameter int TICK_DIV = 100000000,
    parameter int TICK_W   = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pb_start,
    input  logic       pb_set,
    input  logic       pb_inc,
    input  logic       pb_clr,
    input  logic       cnt_zero,
    output logic       de_en,
    output logic       br_s0,
    output logic       set_en,
    output logic [1:0] set_sel,
    output logic [3:0] set_val,
    output logic       rst_f,
    output logic       alarm,
    output logic [2:0] state
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SET   = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_PAUSE = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    localparam logic [TICK_W-1:0] c_TICK_MAX = TICK_W'(TICK_DIV - 1);

    logic [2:0]        r_state,   w_state_nxt;
    logic [TICK_W-1:0] r_presc,   w_presc_nxt;
    logic [1:0]        r_set_sel, w_set_sel_nxt;
    logic [3:0]        r_set_val, w_set_val_nxt;
    logic              r_de_en,   w_de_en_nxt;
    logic              r_br_s0,   w_br_s0_nxt;
    logic              r_set_en,  w_set_en_nxt;
    logic              r_rst_f,   w_rst_f_nxt;
    logic              r_alarm,   w_alarm_nxt;

    logic              w_set, w_start, w_inc;
    logic              w_tick_wrap;
    logic [3:0]        w_digit_max;

    // Only the highest-priority button pressed in a cycle is acted upon.
    assign w_set   = pb_set   & ~pb_clr;
    assign w_start = pb_start & ~pb_clr & ~pb_set;
    assign w_inc   = pb_inc   & ~pb_clr & ~pb_set & ~pb_start;

    assign w_tick_wrap = (r_presc == c_TICK_MAX);
    // Odd digits are tens of seconds/minutes and only go to 5.
    assign w_digit_max = r_set_sel[0] ? 4'd5 : 4'd9;

    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_set_sel_nxt = r_set_sel;
        w_set_val_nxt = r_set_val;
        w_alarm_nxt   = r_alarm;
        w_br_s0_nxt   = 1'b0;
        w_set_en_nxt  = 1'b0;
        w_rst_f_nxt   = 1'b0;

        if (pb_clr) begin
            w_rst_f_nxt   = 1'b1;
            w_state_nxt   = c_ST_IDLE;
            w_presc_nxt   = '0;
            w_set_sel_nxt = 2'd0;
            w_set_val_nxt = 4'd0;
            w_alarm_nxt   = 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_set) begin
                        w_state_nxt   = c_ST_SET;
                        w_set_sel_nxt = 2'd0;
                        w_set_val_nxt = 4'd0;
                    end else if (w_start && !cnt_zero) begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
                c_ST_SET: begin
                    if (w_set) begin
                        w_set_val_nxt = 4'd0;
                        if (r_set_sel == 2'd3) begin
                            w_state_nxt   = c_ST_IDLE;
                            w_set_sel_nxt = 2'd0;
                        end else begin
                            w_set_sel_nxt = r_set_sel + 2'd1;
                        end
                    end else if (w_start) begin
                        w_state_nxt = cnt_zero ? c_ST_IDLE : c_ST_RUN;
                    end else if (w_inc) begin
                        // Strobe and value register together so the chain
                        // loads the post-increment digit.
                        w_set_val_nxt = (r_set_val >= w_digit_max) ? 4'd0
                                                                   : r_set_val + 4'd1;
                        w_set_en_nxt  = 1'b1;
                    end
                end
                c_ST_RUN: begin
                    if (cnt_zero) begin
                        // Terminal count wins over the tick so 00:00 never
                        // borrows into 59:59.
                        w_state_nxt = c_ST_DONE;
                        w_alarm_nxt = 1'b1;
                        w_presc_nxt = '0;
                    end else if (w_start) begin
                        // Prescaler holds: the partial second survives pause.
                        w_state_nxt = c_ST_PAUSE;
                    end else if (w_tick_wrap) begin
                        w_presc_nxt = '0;
                        w_br_s0_nxt = 1'b1;
                    end else begin
                        w_presc_nxt = r_presc + TICK_W'(1);
                    end
                end
                c_ST_PAUSE: begin
                    if (w_set) begin
                        w_state_nxt   = c_ST_SET;
                        w_set_sel_nxt = 2'd0;
                        w_set_val_nxt = 4'd0;
                    end else if (w_start) begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
                c_ST_DONE: begin
                    if (w_set || w_start) begin
                        w_state_nxt = c_ST_IDLE;
                        w_alarm_nxt = 1'b0;
                        w_presc_nxt = '0;
                    end else begin
`ifdef ALARM_BLINK_EN
                        if (w_tick_wrap) begin
                            w_presc_nxt = '0;
                            w_alarm_nxt = ~r_alarm;
                        end else begin
                            w_presc_nxt = r_presc + TICK_W'(1);
                        end
`else
                        w_alarm_nxt = 1'b1;
                        w_presc_nxt = '0;
`endif
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_presc_nxt = '0;
                    w_alarm_nxt = 1'b0;
                end
            endcase
        end

        // A fresh countdown always starts on a whole-second boundary.
        if (w_state_nxt == c_ST_IDLE || w_state_nxt == c_ST_SET) begin
            w_presc_nxt = '0;
        end

        w_de_en_nxt = (w_state_nxt == c_ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_presc   <= '0;
            r_set_sel <= 2'd0;
            r_set_val <= 4'd0;
            r_de_en   <= 1'b0;
            r_br_s0   <= 1'b0;
            r_set_en  <= 1'b0;
            r_rst_f   <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_set_sel <= w_set_sel_nxt;
            r_set_val <= w_set_val_nxt;
            r_de_en   <= w_de_en_nxt;
            r_br_s0   <= w_br_s0_nxt;
            r_set_en  <= w_set_en_nxt;
            r_rst_f   <= w_rst_f_nxt;
            r_alarm   <= w_alarm_nxt;
        end
    end

    assign state   = r_state;
    assign de_en   = r_de_en;
    assign br_s0   = r_br_s0;
    assign set_en  = r_set_en;
    assign set_sel = r_set_sel;
    assign set_val = r_set_val;
    assign rst_f   = r_rst_f;
    assign alarm   = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer_ctrl
// Purpose  : Self-checking bench for countdown_timer_ctrl (TICK_DIV=4).
//            Directed scenarios plus randomized button/cnt_zero traffic,
//            compared every cycle against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer_ctrl;

    localparam int TICK_DIV = 4;
    localparam int TICK_W   = 3;

    localparam logic [3:0] c_B_NONE  = 4'b0000;
    localparam logic [3:0] c_B_INC   = 4'b0001;
    localparam logic [3:0] c_B_START = 4'b0010;
    localparam logic [3:0] c_B_SET   = 4'b0100;
    localparam logic [3:0] c_B_CLR   = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pb_start = 1'b0, pb_set = 1'b0, pb_inc = 1'b0, pb_clr = 1'b0;
    logic       cnt_zero = 1'b0;
    logic       de_en, br_s0, set_en, rst_f, alarm;
    logic [1:0] set_sel;
    logic [3:0] set_val;
    logic [2:0] state;

    always #5 clk = ~clk;

    countdown_timer_ctrl #(.TICK_DIV(TICK_DIV), .TICK_W(TICK_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .pb_start(pb_start), .pb_set(pb_set), .pb_inc(pb_inc), .pb_clr(pb_clr),
        .cnt_zero(cnt_zero),
        .de_en(de_en), .br_s0(br_s0), .set_en(set_en),
        .set_sel(set_sel), .set_val(set_val), .rst_f(rst_f),
        .alarm(alarm), .state(state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode number, elapsed clocks within the current second,
    // selected digit/value, and the registered pulse outputs.
    int m_mode, m_frac, m_sel, m_val;
    int m_de, m_br, m_sen, m_rf, m_alarm;

    int sen_log[$];
    int br_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_frac = 0; m_sel = 0; m_val = 0;
        m_de = 0; m_br = 0; m_sen = 0; m_rf = 0; m_alarm = 0;
    endtask

    task automatic model_step();
        m_br = 0; m_sen = 0; m_rf = 0;
        if (pb_clr) begin
            m_rf = 1; m_mode = 0; m_frac = 0; m_sel = 0; m_val = 0; m_alarm = 0;
        end else begin
            case (m_mode)
                0: if (pb_set) begin m_mode = 1; m_sel = 0; m_val = 0; end
                   else if (pb_start && !cnt_zero) m_mode = 2;
                1: if (pb_set) begin
                       m_val = 0;
                       if (m_sel == 3) begin m_mode = 0; m_sel = 0; end
                       else m_sel = m_sel + 1;
                   end else if (pb_start) m_mode = cnt_zero ? 0 : 2;
                   else if (pb_inc) begin
                       m_val = (m_val + 1) % (((m_sel % 2) == 1) ? 6 : 10);
                       m_sen = 1;
                   end
                2: if (cnt_zero) begin m_mode = 4; m_alarm = 1; m_frac = 0; end
                   else if (pb_start && !pb_set) m_mode = 3;
                   else begin
                       m_frac = m_frac + 1;
                       if (m_frac == TICK_DIV) begin m_frac = 0; m_br = 1; end
                   end
                3: if (pb_set) begin m_mode = 1; m_sel = 0; m_val = 0; end
                   else if (pb_start) m_mode = 2;
                4: if (pb_set || pb_start) begin m_mode = 0; m_alarm = 0; m_frac = 0; end
                   else begin
`ifdef ALARM_BLINK_EN
                       m_frac = m_frac + 1;
                       if (m_frac == TICK_DIV) begin m_frac = 0; m_alarm = 1 - m_alarm; end
`else
                       m_alarm = 1;
`endif
                   end
                default: m_mode = 0;
            endcase
        end
        if (m_mode <= 1) m_frac = 0;
        m_de = (m_mode == 2) ? 1 : 0;
    endtask

    task automatic check_outputs();
        check_val("state",   state,   m_mode);
        check_val("de_en",   de_en,   m_de);
        check_val("br_s0",   br_s0,   m_br);
        check_val("set_en",  set_en,  m_sen);
        check_val("set_sel", set_sel, m_sel);
        check_val("set_val", set_val, m_val);
        check_val("rst_f",   rst_f,   m_rf);
        check_val("alarm",   alarm,   m_alarm);
    endtask

    // Drive buttons {clr,set,start,inc} for one clock, then release them.
    task automatic cycle(input logic [3:0] btn);
        {pb_clr, pb_set, pb_start, pb_inc} = btn;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        if (set_en) sen_log.push_back(int'(set_val));
        if (br_s0) br_cnt++;
        {pb_clr, pb_set, pb_start, pb_inc} = c_B_NONE;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(c_B_NONE);
    endtask

    initial begin
        int exp_sen[10];
        logic [3:0] btn;
        int r;

        exp_sen = '{1, 2, 3, 1, 2, 3, 4, 5, 0, 1};

        // Reset state
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Set mode: 3 increments on sec0, 7 on sec1 (wraps after 5)
        sen_log.delete();
        cycle(c_B_SET);
        for (int i = 0; i < 3; i++) cycle(c_B_INC);
        cycle(c_B_SET);
        for (int i = 0; i < 7; i++) cycle(c_B_INC);
        check_val("set_en_count", sen_log.size(), 10);
        for (int i = 0; i < 10 && i < sen_log.size(); i++)
            check_val("set_val_seq", sen_log[i], exp_sen[i]);
        cycle(c_B_CLR);

        // Countdown: one borrow every 4th clock, stop at 00:00
        cnt_zero = 1'b0;
        cycle(c_B_START);
        check_val("run_state", state, 2);
        check_val("run_de_en", de_en, 1);
        br_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle(c_B_NONE);
            check_val("br_period", br_s0, (i % 4 == 0) ? 1 : 0);
        end
        check_val("br_count", br_cnt, 3);
        cnt_zero = 1'b1;
        cycle(c_B_NONE);
        check_val("done_state", state, 4);
        check_val("done_alarm", alarm, 1);
        check_val("done_no_br", br_s0, 0);
        br_cnt = 0;
        idle(6);
        check_val("done_br_quiet", br_cnt, 0);
        cnt_zero = 1'b0;
        cycle(c_B_START);
        check_val("done_exit", state, 0);

        // Pause keeps the partial second
        cycle(c_B_START);
        idle(2);
        cycle(c_B_START);
        check_val("pause_state", state, 3);
        br_cnt = 0;
        idle(20);
        check_val("pause_no_br", br_cnt, 0);
        cycle(c_B_START);
        cycle(c_B_NONE);
        check_val("resume_br_1", br_s0, 0);
        cycle(c_B_NONE);
        check_val("resume_br_2", br_s0, 1);

        // Clear beats start in the same cycle
        cycle(c_B_CLR | c_B_START);
        check_val("prio_rst_f", rst_f, 1);
        check_val("prio_state", state, 0);
        cycle(c_B_NONE);
        check_val("prio_rst_f_pulse", rst_f, 0);

        // Start ignored at 00:00
        cnt_zero = 1'b1;
        cycle(c_B_START);
        check_val("zero_state", state, 0);
        check_val("zero_de_en", de_en, 0);
        cnt_zero = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 31));
            if (r == 0)      btn = c_B_CLR;
            else if (r < 4)  btn = c_B_SET;
            else if (r < 8)  btn = c_B_START;
            else if (r < 12) btn = c_B_INC;
            else             btn = c_B_NONE;
            cnt_zero = ($urandom_range(0, 23) == 0);
            cycle(btn);
        end
        cnt_zero = 1'b0;

        // Asynchronous reset in the middle of RUN
        cycle(c_B_CLR);
        cycle(c_B_START);
        idle(3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
- Controller that sequences the four-digit BCD down-counter chain (sec0, sec1, min0, min1) of the MM:SS countdown timer.
- Turns debounced one-cycle button pulses into the chain's control strobes: set_en/set value, de_en, rst_f, and the 1 Hz borrow into digit 0.
- Detects the 00:00 terminal count and raises the alarm.
- Sits between the debounce/one-pulse block and the counter chain.

Parameters:
TICK_DIV, 100000000, system clocks per 1 s countdown tick (>=2).
TICK_W, 27, width of the prescaler counter; must hold TICK_DIV-1.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
pb_start  input  1  one-cycle pulse: start/pause toggle
pb_set  input  1  one-cycle pulse: enter set mode / advance digit
pb_inc  input  1  one-cycle pulse: increment selected digit in set mode
pb_clr  input  1  one-cycle pulse: clear time to 00:00
cnt_zero  input  1  high when all four chain digits are 0
de_en  output  1  decrement enable to every chain digit
br_s0  output  1  one-cycle borrow strobe into digit sec0 (the 1 s tick)
set_en  output  1  one-cycle load strobe for the selected digit
set_sel  output  2  selected digit: 0=sec0, 1=sec1, 2=min0, 3=min1
set_val  output  4  BCD value loaded when set_en is high
rst_f  output  1  one-cycle synchronous clear to all digits
alarm  output  1  terminal-count indicator
state  output  3  current FSM state, for the display and debug

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; prescaler=0; set_sel=0; set_val=0; all other outputs 0.
- States: IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4. Codes 5-7 go to IDLE on the next clock.
- Button priority within one cycle: pb_clr > pb_set > pb_start > pb_inc.
- pb_clr in any state:
  - rst_f pulses 1 cycle.
  - Next state is IDLE; prescaler=0; set_sel=0; set_val=0; alarm=0.
- IDLE:
  - pb_set -> SET with set_sel=0, set_val=0.
  - pb_start -> RUN only when cnt_zero=0; otherwise the pulse is ignored.
- SET:
  - pb_inc: set_val becomes set_val+1 with wrap. The wrap limit is 9 for digits 0 and 2, and 5 for digits 1 and 3.
  - set_en pulses in the same cycle the new set_val is registered, so the chain loads the post-increment value.
  - pb_set: set_sel+1 and set_val=0. When set_sel=3, go to IDLE with set_sel=0 instead.
  - pb_start -> RUN when cnt_zero=0, otherwise -> IDLE.
  - de_en=0 throughout SET.
- RUN:
  - de_en=1.
  - The prescaler counts 0..TICK_DIV-1. br_s0 pulses 1 cycle when it wraps from TICK_DIV-1 to 0.
  - pb_start -> PAUSE. The prescaler holds its value, so the remaining fraction of a second is kept across pause/resume.
  - cnt_zero=1 -> DONE next cycle, with alarm=1 and prescaler=0.
  - No br_s0 is issued in the cycle cnt_zero is seen high; 00:00 never wraps to 59:59.
- PAUSE:
  - de_en=0 and br_s0=0.
  - pb_start -> RUN. pb_set -> SET with set_sel=0.
- DONE:
  - alarm=1 and de_en=0.
  - pb_start or pb_set -> IDLE with alarm=0.
- Decrement and borrow:
  - de_en and br_s0 are registered outputs.
  - The chain decrements one clock after the tick edge.
  - cnt_zero is therefore seen by the controller at least 1 cycle after the final br_s0.
- Width rule: the prescaler compare is unsigned, at TICK_W bits.

Optional Feature:
Macro ALARM_BLINK_EN.
- Defined: in DONE, alarm toggles every TICK_DIV clocks, starting at 1 on DONE entry, using the running prescaler. It returns to 0 on leaving DONE.
- Undefined: alarm is held steady at 1 for all of DONE; the prescaler stays idle in DONE.

Test Plan:
- Reset: hold rst_n=0 mid-RUN, then release -> state=0, de_en=0, br_s0=0, alarm=0, set_sel=0, set_val=0 immediately, with no clock edge needed.
- Set mode, TICK_DIV=4: pb_set, 3x pb_inc, pb_set, 7x pb_inc -> set_en pulses 10 times. Values on digit 0 are 1,2,3. Values on digit 1 are 1..5, then 0, then 1, wrapping after 5.
- Countdown, TICK_DIV=4, cnt_zero=0: pb_start -> state=2, de_en=1, br_s0 high every 4th cycle. Raise cnt_zero -> state=4 and alarm=1 next cycle, with no further br_s0.
- Pause: in RUN at prescaler=2, pulse pb_start -> PAUSE, br_s0 stays 0 for 20 cycles. pb_start again -> first br_s0 occurs 2 cycles later.
- Priority: pb_clr and pb_start in the same cycle during RUN -> rst_f=1 for 1 cycle, state=IDLE.
- Zero start: pb_start in IDLE with cnt_zero=1 -> state stays 0, de_en=0.
